// File: rtl/slavefifo2b_bus_arbiter_pkg.sv
// Shared definitions for the FX3 slave-FIFO bus arbiter: state encoding,
// default socket addresses and requester identifiers.
package slavefifo2b_bus_arbiter_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ADDR_SETUP = 3'd1;
    localparam logic [2:0] ST_GRANT_IN   = 3'd2;
    localparam logic [2:0] ST_GRANT_OUT  = 3'd3;
    localparam logic [2:0] ST_TURNAROUND = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE       = ST_IDLE,
        S_ADDR_SETUP = ST_ADDR_SETUP,
        S_GRANT_IN   = ST_GRANT_IN,
        S_GRANT_OUT  = ST_GRANT_OUT,
        S_TURNAROUND = ST_TURNAROUND
    } arb_state_e;

    localparam logic [1:0] DEF_IN_ADDR  = 2'b00;
    localparam logic [1:0] DEF_OUT_ADDR = 2'b11;

    localparam logic WINNER_IN  = 1'b0;
    localparam logic WINNER_OUT = 1'b1;

    // Setup and turnaround lengths are limited to 1..15, so 4 bits hold n-1.
    localparam int unsigned DLY_W = 4;

    function automatic logic [1:0] winner_addr(input logic       winner,
                                               input logic [1:0] in_addr,
                                               input logic [1:0] out_addr);
        return (winner == WINNER_IN) ? in_addr : out_addr;
    endfunction

endpackage

// File: rtl/slavefifo2b_delay_cnt.sv
// Loadable down-counter with a zero flag; shared by the FADDR setup wait
// and the bus turnaround gap.
module slavefifo2b_delay_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/slavefifo2b_bus_arbiter.sv
// Two-way round-robin owner of the FX3 slave-FIFO FADDR bus and DQ direction.
// Optional grant-length preempt hint is built when SLAVEFIFO_BURST_LIMIT_EN is defined.
module slavefifo2b_bus_arbiter
    import slavefifo2b_bus_arbiter_pkg::*;
#(
    parameter int unsigned FLAG_LAT         = 3,
    parameter int unsigned TA_CYCLES        = 2,
    parameter logic [1:0]  IN_ADDR          = DEF_IN_ADDR,
    parameter logic [1:0]  OUT_ADDR         = DEF_OUT_ADDR,
    parameter int unsigned MAX_GRANT_CYCLES = 1024
) (
    input  logic       clk_100,
    input  logic       reset,
    input  logic       in_req,
    input  logic       out_req,
    output logic       in_gnt,
    output logic       out_gnt,
    output logic [1:0] faddr,
    output logic       dq_oe,
    output logic       busy,
    output logic       preempt,
    output logic [2:0] state_dbg
);

    arb_state_e state_q, state_d;
    logic       winner_q, winner_d;
    logic       last_winner_q, last_winner_d;
    logic [1:0] faddr_q, faddr_d;
    logic       in_gnt_q, out_gnt_q;
    logic       busy_q;
    logic       preempt_q;

    logic             cnt_load;
    logic [DLY_W-1:0] cnt_value;
    logic             cnt_dec;
    logic             cnt_zero;

    logic any_req;
    logic pick;
    logic winner_req;

    slavefifo2b_delay_cnt #(
        .W(DLY_W)
    ) u_delay_cnt (
        .clk   (clk_100),
        .reset (reset),
        .load  (cnt_load),
        .value (cnt_value),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        any_req = in_req | out_req;
        if (in_req && out_req) begin
            pick = ~last_winner_q;
        end else if (out_req) begin
            pick = WINNER_OUT;
        end else begin
            pick = WINNER_IN;
        end
        winner_req = (winner_q == WINNER_IN) ? in_req : out_req;
    end

    always_comb begin
        state_d       = state_q;
        winner_d      = winner_q;
        last_winner_d = last_winner_q;
        faddr_d       = faddr_q;
        cnt_load      = 1'b0;
        cnt_value     = '0;
        cnt_dec       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d   = S_ADDR_SETUP;
                    winner_d  = pick;
                    faddr_d   = winner_addr(pick, IN_ADDR, OUT_ADDR);
                    cnt_load  = 1'b1;
                    cnt_value = DLY_W'(FLAG_LAT - 1);
                end
            end
            S_ADDR_SETUP: begin
                if (!winner_req) begin
                    state_d = S_IDLE;
                end else if (cnt_zero) begin
                    state_d       = (winner_q == WINNER_IN) ? S_GRANT_IN : S_GRANT_OUT;
                    last_winner_d = winner_q;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_GRANT_IN, S_GRANT_OUT: begin
                if ((state_q == S_GRANT_IN) ? !in_req : !out_req) begin
                    state_d   = S_TURNAROUND;
                    cnt_load  = 1'b1;
                    cnt_value = DLY_W'(TA_CYCLES - 1);
                end
            end
            S_TURNAROUND: begin
                // The last gap cycle doubles as the IDLE arbitration cycle.
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (any_req) begin
                    state_d   = S_ADDR_SETUP;
                    winner_d  = pick;
                    faddr_d   = winner_addr(pick, IN_ADDR, OUT_ADDR);
                    cnt_load  = 1'b1;
                    cnt_value = DLY_W'(FLAG_LAT - 1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100) begin
        if (reset) begin
            state_q       <= S_IDLE;
            winner_q      <= WINNER_IN;
            last_winner_q <= WINNER_IN;
            faddr_q       <= OUT_ADDR;
            in_gnt_q      <= 1'b0;
            out_gnt_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            winner_q      <= winner_d;
            last_winner_q <= last_winner_d;
            faddr_q       <= faddr_d;
            in_gnt_q      <= (state_d == S_GRANT_IN);
            out_gnt_q     <= (state_d == S_GRANT_OUT);
            busy_q        <= (state_d != S_IDLE);
        end
    end

`ifdef SLAVEFIFO_BURST_LIMIT_EN
    logic [15:0] gcnt_q, gcnt_d;
    logic        preempt_d;
    logic        holding;
    logic        other_req;
    logic        limit_hit;

    always_comb begin
        holding   = (state_q == S_GRANT_IN) || (state_q == S_GRANT_OUT);
        other_req = (state_q == S_GRANT_IN) ? out_req : in_req;
        limit_hit = (32'(gcnt_q) >= (MAX_GRANT_CYCLES - 1));

        gcnt_d = gcnt_q;
        if (!holding) begin
            gcnt_d = '0;
        end else if (gcnt_q != 16'hFFFF) begin
            gcnt_d = gcnt_q + 16'd1;
        end

        // Sticky until the holder releases; the grant itself is never revoked.
        preempt_d = 1'b0;
        if (holding && (state_d == state_q)) begin
            preempt_d = preempt_q || (limit_hit && other_req);
        end
    end

    always_ff @(posedge clk_100) begin
        if (reset) begin
            gcnt_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            gcnt_q    <= gcnt_d;
            preempt_q <= preempt_d;
        end
    end
`else
    logic unused_burst_cfg;
    assign unused_burst_cfg = (MAX_GRANT_CYCLES != 0);
    assign preempt_q        = 1'b0;
`endif

    assign in_gnt    = in_gnt_q;
    assign out_gnt   = out_gnt_q;
    assign dq_oe     = in_gnt_q;
    assign faddr     = faddr_q;
    assign busy      = busy_q;
    assign preempt   = preempt_q;
    assign state_dbg = state_q;

endmodule

// File: doc/slavefifo2b_bus_arbiter.md
Name: slavefifo2b_bus_arbiter

Overview:
Shares the FX3 slave-FIFO 2-bit-address bus between the stream-IN writer (FPGA->FX3) and the stream-OUT reader (FX3->FPGA).
- Selects the socket address and holds it for the FX3 flag-latency settle time before granting.
- Enforces a bus turnaround gap on release and arbitrates round-robin when both requesters are pending.
- Sits between the per-direction streaming state machines and the GPIF II pins; it drives FADDR and the DQ output-enable direction, while requesters drive SLWR/SLRD/SLOE/PKTEND.

Parameters:
FLAG_LAT, 3, cycles FADDR is held stable before grant (FX3 flag update latency), legal 1..15
TA_CYCLES, 2, idle cycles after release before the next address change, legal 1..15
IN_ADDR, 2'b00, FADDR value for the stream-IN (write) socket
OUT_ADDR, 2'b11, FADDR value for the stream-OUT (read) socket
MAX_GRANT_CYCLES, 1024, grant length after which preempt is raised (optional feature only), legal 1..65535

Ports:
clk_100  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high reset
in_req  in  1  stream-IN writer requests bus; held high for whole transaction
out_req  in  1  stream-OUT reader requests bus; held high until its SLOE drain completes
in_gnt  out  1  stream-IN owns bus
out_gnt  out  1  stream-OUT owns bus
faddr  out  2  registered FX3 FIFO address
dq_oe  out  1  1 = FPGA drives DQ[31:0]; high only while in_gnt
busy  out  1  high in every state except IDLE
preempt  out  1  request to current holder to finish and drop req

Behaviour:
- Reset (sync, sampled at clk_100 edge) gives: state IDLE, in_gnt=0, out_gnt=0, dq_oe=0, faddr=OUT_ADDR, busy=0, preempt=0, last_winner=IN, counters 0. Reset mid-grant revokes the grant at that edge with no turnaround.
- All outputs are registered. in_gnt and out_gnt are never both high. dq_oe equals in_gnt.
- States: IDLE, ADDR_SETUP, GRANT_IN, GRANT_OUT, TURNAROUND.
- IDLE:
  - Only in_req or only out_req high: winner is that requester.
  - Both high: winner is the one not equal to last_winner (first tie after reset goes to OUT).
  - With a winner: faddr <= winner address, cnt <= FLAG_LAT-1, go to ADDR_SETUP.
- ADDR_SETUP:
  - Decrement cnt each cycle; when cnt==0, go to GRANT_IN or GRANT_OUT and record last_winner.
  - Grant is therefore visible FLAG_LAT cycles after the edge that left IDLE.
  - If the winner's req drops during setup, go to IDLE with no grant and last_winner unchanged.
- GRANT_x: gnt stays high while x_req is high. When x_req is sampled low, gnt clears at that edge, cnt <= TA_CYCLES-1, go to TURNAROUND.
- TURNAROUND: gnt=0, dq_oe=0, faddr unchanged. When cnt==0, go directly to IDLE's arbitration: if any req is pending, enter ADDR_SETUP at the same edge; otherwise go to IDLE.
- A losing requester's req is ignored until the grant releases. The arbiter never revokes a grant on its own; the slave-FIFO protocol must complete cleanly.
- faddr changes only on entry to ADDR_SETUP.

Optional Feature:
SLAVEFIFO_BURST_LIMIT_EN
- Enabled:
  - A 16-bit grant counter clears on entry to GRANT_x and saturates.
  - When count >= MAX_GRANT_CYCLES-1 and the other req is high, preempt goes high on the next edge.
  - preempt stays high until the grant releases and clears with gnt.
  - The holder is still not revoked; it must finish and drop req.
- Disabled: preempt is tied 0, no counter is built, and grants are unbounded.

Decomposition:
- Shared package: state encoding (3-bit localparams IDLE=0, ADDR_SETUP=1, GRANT_IN=2, GRANT_OUT=3, TURNAROUND=4), IN_ADDR/OUT_ADDR defaults, WINNER_IN/WINNER_OUT constants.
- Sub-module: a down-counter slavefifo2b_delay_cnt (load, value, zero flag), used for both the setup and turnaround counts.
- Round-robin logic stays inline; it is two-way and too small to split out.

Test Plan:
1. Reset, then in_req high before edge 0 -> faddr=2'b00 after edge 0; in_gnt=1, dq_oe=1 after edge 3; out_gnt stays 0.
2. in_gnt held, in_req low before edge 10 -> in_gnt=0, dq_oe=0 after edge 10; busy=1 through edge 11; busy=0 after edge 12.
3. in_req and out_req high from reset -> OUT granted first (faddr=2'b11). out_req drops; 2 turnaround cycles follow; faddr=2'b00 on the next edge; in_gnt 3 cycles later.
4. out_req pulse of 2 cycles (drops during ADDR_SETUP) -> no grant, return to IDLE. A subsequent in_req+out_req tie still goes to OUT.
5. reset asserted during GRANT_OUT -> out_gnt=0, faddr=2'b11, state IDLE after the same edge; no TURNAROUND.
6. SLAVEFIFO_BURST_LIMIT_EN, MAX_GRANT_CYCLES=8, IN granted, out_req high -> preempt=1 after the 8th grant edge, clears when in_req drops. Without the macro, preempt stays 0 for 100 cycles.
